rect_overlay: RTL

RECT_OVERLAY -- requirements
Module: rect_overlay

---
 rtl/rect_overlay.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/rect_overlay.sv
// Rectangle overlay: shadow/active rectangle sets with a two-stage hit/priority pipeline.
// Optional define RECT_OUTLINE_EN adds a per-channel outline mode and the wr_outline port.
`timescale 1ns/1ps
module rect_overlay #(
    parameter int NUM_RECTS = 4,
    parameter int COORD_W   = 10,
    parameter int COLOR_W   = 8,
    localparam int IDX_W    = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COORD_W-1:0] wr_w,
    input  logic [COORD_W-1:0] wr_h,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               wr_en_rect,
`ifdef RECT_OUTLINE_EN
    input  logic               wr_outline,
`endif
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] x_pixel,
    input  logic [COORD_W-1:0] y_pixel,
    output logic               out_valid,
    output logic               out_hit,
    output logic [IDX_W-1:0]   out_idx,
    output logic [COLOR_W-1:0] out_color
);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic [COLOR_W-1:0] color;
        logic               en;
`ifdef RECT_OUTLINE_EN
        logic               outline;
`endif
    } rect_t;

    rect_t                shadow_q [NUM_RECTS];
    rect_t                active_q [NUM_RECTS];
    rect_t                wr_rect;
    logic                 rdy_q;

    logic [NUM_RECTS-1:0] hit_d;
    logic                 v1_q;
    logic [NUM_RECTS-1:0] hit1_q;
    logic [COLOR_W-1:0]   col1_q [NUM_RECTS];

    logic                 win_hit_d;
    logic [IDX_W-1:0]     win_idx_d;
    logic [COLOR_W-1:0]   win_color_d;
    logic                 out_valid_q;
    logic                 out_hit_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic [COLOR_W-1:0]   out_color_q;

    // Writes stall during the commit cycle so a commit never races a shadow update.
    assign wr_ready = rdy_q && !frame_start;

    always_comb begin
        wr_rect       = '0;
        wr_rect.x     = wr_x;
        wr_rect.y     = wr_y;
        wr_rect.w     = wr_w;
        wr_rect.h     = wr_h;
        wr_rect.color = wr_color;
        wr_rect.en    = wr_en_rect;
`ifdef RECT_OUTLINE_EN
        wr_rect.outline = wr_outline;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_RECTS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            rdy_q <= 1'b1;
            if (wr_valid && wr_ready)
                shadow_q[wr_idx] <= wr_rect;
            if (frame_start)
                active_q <= shadow_q;
        end
    end

    // Bounds are compared one bit wider than coordinates so x+w clips instead of wrapping.
    always_comb begin : hit_calc
        logic [COORD_W:0] px, py, x_end, y_end;
        logic             in_rect, on_edge;
        hit_d   = '0;
        px      = {1'b0, x_pixel};
        py      = {1'b0, y_pixel};
        x_end   = '0;
        y_end   = '0;
        in_rect = 1'b0;
        on_edge = 1'b0;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            x_end   = {1'b0, active_q[i].x} + {1'b0, active_q[i].w};
            y_end   = {1'b0, active_q[i].y} + {1'b0, active_q[i].h};
            in_rect = active_q[i].en
                   && (px >= {1'b0, active_q[i].x}) && (px < x_end)
                   && (py >= {1'b0, active_q[i].y}) && (py < y_end);
            on_edge = (px == {1'b0, active_q[i].x}) || (px == x_end - (COORD_W+1)'(1))
                   || (py == {1'b0, active_q[i].y}) || (py == y_end - (COORD_W+1)'(1));
`ifdef RECT_OUTLINE_EN
            hit_d[i] = in_rect && (!active_q[i].outline || on_edge);
`else
            hit_d[i] = in_rect && (on_edge || !on_edge);
`endif
        end
    end

    // Colours are captured with the hit vector so a commit cannot alter in-flight pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            hit1_q <= '0;
            for (int unsigned i = 0; i < NUM_RECTS; i++)
                col1_q[i] <= '0;
        end else begin
            v1_q   <= pix_valid;
            hit1_q <= pix_valid ? hit_d : '0;
            for (int unsigned i = 0; i < NUM_RECTS; i++)
                col1_q[i] <= active_q[i].color;
        end
    end

    always_comb begin
        win_hit_d   = 1'b0;
        win_idx_d   = '0;
        win_color_d = '0;
        for (int unsigned i = 0; i < NUM_RECTS; i++) begin
            if (hit1_q[i] && !win_hit_d) begin
                win_hit_d   = 1'b1;
                win_idx_d   = IDX_W'(i);
                win_color_d = col1_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
            out_color_q <= '0;
        end else begin
            out_valid_q <= v1_q;
            out_hit_q   <= win_hit_d;
            out_idx_q   <= win_idx_d;
            out_color_q <= win_color_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_idx   = out_idx_q;
    assign out_color = out_color_q;

endmodule
